// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_L = 1'b1
  } owner_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and RAM-macro signals shared by the arbiter and its surroundings.
interface imem_arbiter_if #(
  parameter int unsigned ADDR_W = imem_pkg::ADDR_W,
  parameter int unsigned DATA_W = imem_pkg::DATA_W
);

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;
  logic              l_done;
  logic              boot_done;

  logic              im_cen;
  logic              im_wen;
  logic              im_oen;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_datain;
  logic [DATA_W-1:0] im_dataout;

  // Arbiter side
  modport slave (
    input  f_req, f_addr,
    output f_gnt, f_rvalid, f_rdata,
    input  l_req, l_we, l_addr, l_wdata, l_done,
    output l_gnt, l_rvalid, l_rdata, boot_done,
    output im_cen, im_wen, im_oen, im_addr, im_datain,
    input  im_dataout
  );

  // Requester / RAM side
  modport master (
    output f_req, f_addr,
    input  f_gnt, f_rvalid, f_rdata,
    output l_req, l_we, l_addr, l_wdata, l_done,
    input  l_gnt, l_rvalid, l_rdata, boot_done,
    input  im_cen, im_wen, im_oen, im_addr, im_datain,
    output im_dataout
  );

endinterface

// File: rtl/imem_arbiter_starve_cnt.sv
// Counts consecutive loader denials; asserts forced once the limit is reached.
module starve_cnt #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic gnt,
  output logic forced
);

  localparam logic [3:0] MAX = 4'(STARVE_MAX);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req || gnt) begin
      cnt_d = '0;
    end else if (cnt_q < MAX) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign forced = (cnt_q == MAX);

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single instruction RAM between fetch and the loader/debug port,
// with a loader-only boot phase followed by fetch-priority run mode.
module imem_arbiter #(
  parameter int unsigned ADDR_W     = imem_pkg::ADDR_W,
  parameter int unsigned DATA_W     = imem_pkg::DATA_W,
  parameter int unsigned STARVE_MAX = 4,
  parameter bit          BOOT_EN    = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  imem_arbiter_if.slave  bus
);

  import imem_pkg::*;

  localparam state_e RST_STATE = BOOT_EN ? BOOT : RUN;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              rd_valid_q, rd_valid_d;
  logic              forced;
  logic              f_gnt, l_gnt;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] rdata;

  // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
  always_comb begin
    f_gnt      = 1'b0;
    l_gnt      = 1'b0;
    state_d    = state_q;
    owner_d    = owner_q;
    rd_valid_d = 1'b0;
    addr_sel   = bus.l_addr;

    if (rst_n) begin
      if (state_q == RUN && bus.f_req && !forced) begin
        f_gnt = 1'b1;
      end else begin
        l_gnt = bus.l_req;
      end
    end

    if (state_q == BOOT && bus.l_done) begin
      state_d = RUN;
    end

    rd_valid_d = f_gnt | (l_gnt & ~bus.l_we);
    if (rd_valid_d) begin
      owner_d = f_gnt ? OWN_F : OWN_L;
    end
    if (f_gnt) begin
      addr_sel = bus.f_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      owner_q    <= OWN_F;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (bus.l_req),
    .gnt    (l_gnt),
    .forced (forced)
  );

  assign rdata         = bus.im_dataout;

  assign bus.f_gnt     = f_gnt;
  assign bus.l_gnt     = l_gnt;
  assign bus.f_rvalid  = rd_valid_q && (owner_q == OWN_F);
  assign bus.l_rvalid  = rd_valid_q && (owner_q == OWN_L);
  assign bus.f_rdata   = rdata;
  assign bus.l_rdata   = rdata;
  assign bus.boot_done = (state_q == RUN);

  assign bus.im_cen    = ~(f_gnt | l_gnt);
  assign bus.im_wen    = ~(l_gnt & bus.l_we);
  assign bus.im_oen    = 1'b0;
  assign bus.im_addr   = addr_sel;
  assign bus.im_datain = bus.l_wdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: boot, read-back, starvation, writes, reset, no-boot.
module tb_imem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  imem_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus0 ();
  imem_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus1 ();

  imem_arbiter #(
    .ADDR_W(11), .DATA_W(32), .STARVE_MAX(4), .BOOT_EN(1'b1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  imem_arbiter #(
    .ADDR_W(11), .DATA_W(32), .STARVE_MAX(4), .BOOT_EN(1'b0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  logic [31:0] mem [0:2047];

  always @(posedge clk) begin
    if (!bus0.im_cen) begin
      if (!bus0.im_wen) mem[bus0.im_addr] <= bus0.im_datain;
      else              bus0.im_dataout  <= mem[bus0.im_addr];
    end
  end

  assign bus1.im_dataout = 32'hA5A5_A5A5;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] boot_data [3];
  logic        prev_l;

  initial begin
    boot_data[0] = 32'h11;
    boot_data[1] = 32'h22;
    boot_data[2] = 32'h33;

    rst_n        = 1'b0;
    bus0.f_req   = 1'b1;  bus0.f_addr  = '0;
    bus0.l_req   = 1'b1;  bus0.l_we    = 1'b0;
    bus0.l_addr  = '0;    bus0.l_wdata = '0;  bus0.l_done = 1'b0;
    bus1.f_req   = 1'b1;  bus1.f_addr  = 11'h10;
    bus1.l_req   = 1'b0;  bus1.l_we    = 1'b0;
    bus1.l_addr  = '0;    bus1.l_wdata = '0;  bus1.l_done = 1'b0;

    // Reset values with requests asserted
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f_gnt",     32'(bus0.f_gnt),     32'd0);
    chk("rst_l_gnt",     32'(bus0.l_gnt),     32'd0);
    chk("rst_f_rvalid",  32'(bus0.f_rvalid),  32'd0);
    chk("rst_l_rvalid",  32'(bus0.l_rvalid),  32'd0);
    chk("rst_boot_done", 32'(bus0.boot_done), 32'd0);
    chk("rst_im_cen",    32'(bus0.im_cen),    32'd1);
    chk("rst_im_wen",    32'(bus0.im_wen),    32'd1);
    chk("rst_im_oen",    32'(bus0.im_oen),    32'd0);
    chk("nb_rst_boot",   32'(bus1.boot_done), 32'd1);
    chk("nb_rst_f_gnt",  32'(bus1.f_gnt),     32'd0);

    rst_n = 1'b1;
    #1;
    // No-boot instance grants fetch immediately
    chk("nb_f_gnt",      32'(bus1.f_gnt),     32'd1);
    chk("nb_im_addr",    32'(bus1.im_addr),   32'h10);
    tick();
    bus1.f_req = 1'b0;
    #1;
    chk("nb_f_rvalid",   32'(bus1.f_rvalid),  32'd1);
    chk("nb_f_rdata",    bus1.f_rdata,        32'hA5A5_A5A5);

    // Boot: fetch held high but blocked, loader writes image
    for (int i = 0; i < 3; i++) begin
      bus0.l_req   = 1'b1;
      bus0.l_we    = 1'b1;
      bus0.l_addr  = 11'(i);
      bus0.l_wdata = boot_data[i];
      #1;
      chk("boot_f_gnt",  32'(bus0.f_gnt),   32'd0);
      chk("boot_l_gnt",  32'(bus0.l_gnt),   32'd1);
      chk("boot_im_wen", 32'(bus0.im_wen),  32'd0);
      chk("boot_addr",   32'(bus0.im_addr), 32'(i));
      tick();
    end
    bus0.l_req  = 1'b0;
    bus0.l_we   = 1'b0;
    bus0.l_done = 1'b1;
    #1;
    chk("done_f_gnt",     32'(bus0.f_gnt),     32'd0);
    chk("done_boot_done", 32'(bus0.boot_done), 32'd0);
    chk("done_im_cen",    32'(bus0.im_cen),    32'd1);
    chk("wr_no_l_rvalid", 32'(bus0.l_rvalid),  32'd0);
    tick();

    // First RUN cycle: both request, fetch wins; then read-back
    bus0.l_done = 1'b0;
    bus0.f_addr = 11'd0;
    bus0.l_req  = 1'b1;
    bus0.l_we   = 1'b0;
    bus0.l_addr = 11'd2;
    #1;
    chk("run_boot_done", 32'(bus0.boot_done), 32'd1);
    chk("run0_f_gnt",    32'(bus0.f_gnt),     32'd1);
    chk("run0_l_gnt",    32'(bus0.l_gnt),     32'd0);
    chk("run0_f_rvalid", 32'(bus0.f_rvalid),  32'd0);
    tick();
    bus0.f_addr = 11'd1;
    #1;
    chk("rb1_f_gnt",     32'(bus0.f_gnt),     32'd1);
    chk("rb1_f_rvalid",  32'(bus0.f_rvalid),  32'd1);
    chk("rb1_f_rdata",   bus0.f_rdata,        32'h11);
    tick();
    bus0.f_addr = 11'd2;
    #1;
    chk("rb2_f_rvalid",  32'(bus0.f_rvalid),  32'd1);
    chk("rb2_f_rdata",   bus0.f_rdata,        32'h22);
    tick();
    bus0.f_req = 1'b0;
    #1;
    chk("rb3_f_rvalid",  32'(bus0.f_rvalid),  32'd1);
    chk("rb3_f_rdata",   bus0.f_rdata,        32'h33);
    chk("rb3_l_gnt",     32'(bus0.l_gnt),     32'd1);
    chk("rb3_im_addr",   32'(bus0.im_addr),   32'd2);
    tick();
    bus0.l_req = 1'b0;
    #1;
    chk("lrd_f_rvalid",  32'(bus0.f_rvalid),  32'd0);
    chk("lrd_l_rvalid",  32'(bus0.l_rvalid),  32'd1);
    chk("lrd_l_rdata",   bus0.l_rdata,        32'h33);
    chk("idle_im_cen",   32'(bus0.im_cen),    32'd1);
    tick();

    // Starvation: loader forced every 5th cycle
    bus0.f_req  = 1'b1;
    bus0.f_addr = 11'd0;
    bus0.l_req  = 1'b1;
    bus0.l_we   = 1'b0;
    bus0.l_addr = 11'd5;
    prev_l      = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("stv_l_gnt", 32'(bus0.l_gnt), 32'((k % 5) == 4));
      chk("stv_f_gnt", 32'(bus0.f_gnt), 32'((k % 5) != 4));
      if (k > 0) begin
        chk("stv_l_rvalid", 32'(bus0.l_rvalid), 32'(prev_l));
        chk("stv_f_rvalid", 32'(bus0.f_rvalid), 32'(!prev_l));
      end
      prev_l = ((k % 5) == 4);
      tick();
    end
    bus0.f_req = 1'b0;
    bus0.l_req = 1'b0;
    tick();

    // Write qualification in RUN
    bus0.l_req   = 1'b1;
    bus0.l_we    = 1'b1;
    bus0.l_addr  = 11'h7FF;
    bus0.l_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wq_l_gnt",   32'(bus0.l_gnt),     32'd1);
    chk("wq_im_wen",  32'(bus0.im_wen),    32'd0);
    chk("wq_datain",  bus0.im_datain,      32'hDEAD_BEEF);
    chk("wq_addr",    32'(bus0.im_addr),   32'h7FF);
    tick();
    bus0.l_req = 1'b0;
    bus0.l_we  = 1'b0;
    #1;
    chk("wq_wen_off",   32'(bus0.im_wen),   32'd1);
    chk("wq_no_rvalid", 32'(bus0.l_rvalid), 32'd0);
    tick();
    bus0.l_req = 1'b1;
    #1;
    chk("rq_l_gnt",  32'(bus0.l_gnt),  32'd1);
    chk("rq_im_wen", 32'(bus0.im_wen), 32'd1);
    tick();
    bus0.l_req = 1'b0;
    #1;
    chk("rq_l_rvalid", 32'(bus0.l_rvalid), 32'd1);
    chk("rq_l_rdata",  bus0.l_rdata,       32'hDEAD_BEEF);
    chk("rq_f_rvalid", 32'(bus0.f_rvalid), 32'd0);
    tick();

    // Reset after a registered read: rvalid drops asynchronously
    bus0.f_req  = 1'b1;
    bus0.f_addr = 11'd1;
    #1;
    chk("mr_f_gnt", 32'(bus0.f_gnt), 32'd1);
    tick();
    #1;
    chk("mr_f_rvalid_pre", 32'(bus0.f_rvalid), 32'd1);
    chk("mr_f_rdata_pre",  bus0.f_rdata,       32'h22);
    rst_n = 1'b0;
    #1;
    chk("mr_f_rvalid_async", 32'(bus0.f_rvalid),  32'd0);
    chk("mr_im_cen",         32'(bus0.im_cen),    32'd1);
    chk("mr_boot_done",      32'(bus0.boot_done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset landing between a grant and its data edge
    bus0.l_done = 1'b1;
    tick();
    bus0.l_done = 1'b0;
    #1;
    chk("mr2_f_gnt", 32'(bus0.f_gnt), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr2_f_gnt_rst", 32'(bus0.f_gnt),  32'd0);
    chk("mr2_im_cen",    32'(bus0.im_cen), 32'd1);
    tick();
    chk("mr2_f_rvalid",  32'(bus0.f_rvalid),  32'd0);
    chk("mr2_boot_done", 32'(bus0.boot_done), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mr2_boot_block", 32'(bus0.f_gnt), 32'd0);
    tick();
    chk("mr2_f_rvalid_post", 32'(bus0.f_rvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
